// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default baud/watchdog settings
// and the transmit scheduler state encoding.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_CLK_DIV       = 434;
    localparam int UART_TIMEOUT_TICKS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        GUARD = 2'd3
    } sched_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running baud tick: one-cycle pulse every CLK_DIV clocks,
// high while the internal counter sits at CLK_DIV-1.
module baud_tick_gen #(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CW'(CLK_DIV - 1));
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ
// byte producers, with guard gap and stuck-transmitter watchdog.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int CLK_DIV       = UART_CLK_DIV,
    parameter int GUARD_TICKS   = 2,
    parameter int TIMEOUT_TICKS = UART_TIMEOUT_TICKS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           tick,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_done,
    output logic                           busy,
    output logic [$clog2(N_REQ)-1:0]       grant_id,
    output logic                           timeout_err
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int GC_W = $clog2(GUARD_TICKS + 1);

    sched_state_t           state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        gid_q, gid_d;
    logic [N_REQ-1:0]       rdy_q, rdy_d;
    logic                   start_q, start_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   to_q, to_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [GC_W-1:0]        gc_q, gc_d;

    logic [ID_W-1:0]        win;
    logic                   found;

    baud_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx   = 0;
        win   = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        rdy_d   = '0;
        start_d = start_q;
        data_d  = data_q;
        to_d    = 1'b0;
        wd_d    = wd_q;
        gc_d    = gc_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    ptr_d      = win;
                    gid_d      = win;
                    rdy_d[win] = 1'b1;
                    data_d     = req_data[int'(win)*UART_DATA_W +: UART_DATA_W];
                    wd_d       = '0;
                end
            end
            GRANT: begin
                state_d = SEND;
                start_d = 1'b1;
            end
            SEND: begin
                // A done seen on the limit tick still counts as success.
                if (tx_done) begin
                    state_d = GUARD;
                    start_d = 1'b0;
                    gc_d    = '0;
                end else if (tick) begin
                    if (wd_q == WD_W'(TIMEOUT_TICKS - 1)) begin
                        state_d = GUARD;
                        start_d = 1'b0;
                        to_d    = 1'b1;
                        gc_d    = '0;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            GUARD: begin
                if (tick) begin
                    if (gc_q == GC_W'(GUARD_TICKS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        gc_d = gc_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(N_REQ - 1);
            gid_q   <= '0;
            rdy_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            to_q    <= 1'b0;
            wd_q    <= '0;
            gc_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            rdy_q   <= rdy_d;
            start_q <= start_d;
            data_q  <= data_d;
            to_q    <= to_d;
            wd_q    <= wd_d;
            gc_q    <= gc_d;
        end
    end

    assign req_ready   = rdy_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign timeout_err = to_q;
    assign busy        = (state_q != IDLE);

endmodule
